alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 85 ++++++++
 rtl/alu_pipe.sv | 109 ++++++++++
 tb/tb_alu_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default opcode width, flag bit
// positions and the internal decoded-operation enum.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OP_BITS_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // o_flags = {carry, overflow, negative, zero}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SRL, ALU_SRA, ALU_BAD
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the two pipeline stages.
// Flag generation is present only when ALU_PIPE_FLAGS_EN is defined.
`timescale 1ns/1ps
module alu_core import alu_pkg::*; #(
  parameter int N_BITS  = 8,
  parameter int OP_BITS = OP_BITS_DEF
) (
  input  logic [N_BITS-1:0]  a_i,
  input  logic [N_BITS-1:0]  b_i,
  input  logic [OP_BITS-1:0] op_i,
  output logic [N_BITS-1:0]  res_o,
  output logic               err_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]         flags_o
`endif
);

  alu_op_e op_kind;

`ifdef ALU_PIPE_FLAGS_EN
  // Extra top bit carries the carry-out / not-borrow.
  logic [N_BITS:0] add_w;
  logic [N_BITS:0] sub_w;
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + (N_BITS+1)'(1);
`else
  logic [N_BITS-1:0] add_w;
  logic [N_BITS-1:0] sub_w;
  assign add_w = a_i + b_i;
  assign sub_w = a_i - b_i;
`endif

  always_comb begin
    op_kind = ALU_BAD;
    case (op_i)
      OP_BITS'(OP_ADD): op_kind = ALU_ADD;
      OP_BITS'(OP_SUB): op_kind = ALU_SUB;
      OP_BITS'(OP_AND): op_kind = ALU_AND;
      OP_BITS'(OP_OR):  op_kind = ALU_OR;
      OP_BITS'(OP_XOR): op_kind = ALU_XOR;
      OP_BITS'(OP_NOR): op_kind = ALU_NOR;
      OP_BITS'(OP_SRL): op_kind = ALU_SRL;
      OP_BITS'(OP_SRA): op_kind = ALU_SRA;
      default:          op_kind = ALU_BAD;
    endcase
  end

  // Shift operators already saturate to zero / sign fill for B >= N_BITS.
  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (op_kind)
      ALU_ADD: res_o = add_w[N_BITS-1:0];
      ALU_SUB: res_o = sub_w[N_BITS-1:0];
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOR: res_o = ~(a_i | b_i);
      ALU_SRL: res_o = a_i >> b_i;
      ALU_SRA: res_o = $unsigned($signed(a_i) >>> b_i);
      default: err_o = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  always_comb begin
    flags_o = '0;
    if (op_kind != ALU_BAD) begin
      flags_o[FLAG_Z] = (res_o == '0);
      flags_o[FLAG_N] = res_o[N_BITS-1];
    end
    if (op_kind == ALU_ADD) begin
      flags_o[FLAG_C] = add_w[N_BITS];
      flags_o[FLAG_V] = (a_i[N_BITS-1] == b_i[N_BITS-1]) &&
                        (res_o[N_BITS-1] != a_i[N_BITS-1]);
    end else if (op_kind == ALU_SUB) begin
      flags_o[FLAG_C] = sub_w[N_BITS];
      flags_o[FLAG_V] = (a_i[N_BITS-1] != b_i[N_BITS-1]) &&
                        (res_o[N_BITS-1] != a_i[N_BITS-1]);
    end
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Define ALU_PIPE_FLAGS_EN to add the o_flags port and its S2 register.
`timescale 1ns/1ps
module alu_pipe import alu_pkg::*; #(
  parameter int N_BITS  = 8,
  parameter int OP_BITS = OP_BITS_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N_BITS-1:0]  i_A,
  input  logic [N_BITS-1:0]  i_B,
  input  logic [OP_BITS-1:0] i_OP,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N_BITS-1:0]  o_res,
  output logic               o_err
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]         o_flags
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds data stable while valid && !ready; o_ready looks at
  // whether S2 drains this cycle, so a full pipe still streams without a bubble.

  logic               s1_valid_q, s1_valid_d;
  logic [N_BITS-1:0]  a_q, a_d;
  logic [N_BITS-1:0]  b_q, b_d;
  logic [OP_BITS-1:0] op_q, op_d;
  logic               s2_valid_q, s2_valid_d;
  logic [N_BITS-1:0]  res_q, res_d;
  logic               err_q, err_d;
  logic [N_BITS-1:0]  core_res;
  logic               core_err;
  logic               s1_load, s2_load, accept;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         core_flags;
`endif

  alu_core #(
    .N_BITS  (N_BITS),
    .OP_BITS (OP_BITS)
  ) u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_o   (core_res),
    .err_o   (core_err)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags_o (core_flags)
`endif
  );

  always_comb begin
    s2_load    = !s2_valid_q || i_ready;
    s1_load    = !s1_valid_q || s2_load;
    accept     = i_valid && s1_load;
    s1_valid_d = s1_load ? accept : s1_valid_q;
    a_d        = accept ? i_A  : a_q;
    b_d        = accept ? i_B  : b_q;
    op_d       = accept ? i_OP : op_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    res_d      = (s2_load && s1_valid_q) ? core_res : res_q;
    err_d      = (s2_load && s1_valid_q) ? core_err : err_q;
`ifdef ALU_PIPE_FLAGS_EN
    flags_d    = (s2_load && s1_valid_q) ? core_flags : flags_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
      flags_q    <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      err_q      <= err_d;
`ifdef ALU_PIPE_FLAGS_EN
      flags_q    <= flags_d;
`endif
    end
  end

  assign o_ready = s1_load;
  assign o_valid = s2_valid_q;
  assign o_res   = res_q;
  assign o_err   = err_q;
`ifdef ALU_PIPE_FLAGS_EN
  assign o_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed spec cases plus randomized
// traffic against an arithmetic reference model and an expected queue.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int N = 8;
  localparam int W = N + 5;
  localparam int M = 1 << N;
  localparam int H = 1 << (N - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic         o_ready, o_valid, o_err;
  logic [N-1:0] a = '0, b = '0, o_res;
  logic [5:0]   op = '0;
  logic [3:0]   flags_obs;

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] o_flags;
  assign flags_obs = o_flags;
  localparam logic [3:0] FMASK = 4'hF;
`else
  assign flags_obs = 4'h0;
  localparam logic [3:0] FMASK = 4'h0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_in     = 0;
  int n_out    = 0;
  logic [W-1:0] exp_q[$];

  alu_pipe #(.N_BITS(N), .OP_BITS(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_A     (a),
    .i_B     (b),
    .i_OP    (op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_err   (o_err)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .o_flags (o_flags)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [N-1:0] av, bv, input logic [5:0] opv);
    int ua, ub, sa, sb, full, r, sr;
    logic c, v, e;
    logic [3:0] f;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= H) ? ua - M : ua;
    sb = (ub >= H) ? ub - M : ub;
    c = 1'b0; v = 1'b0; e = 1'b0; r = 0;
    case (opv)
      OP_ADD: begin
        full = ua + ub; r = full % M; c = (full >= M);
        sr = sa + sb; v = (sr >= H) || (sr < -H);
      end
      OP_SUB: begin
        r = (ua - ub + M) % M; c = (ua >= ub);
        sr = sa - sb; v = (sr >= H) || (sr < -H);
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOR: r = (M - 1) - (ua | ub);
      OP_SRL: r = (ub >= N) ? 0 : ua / (1 << ub);
      OP_SRA: begin
        if (ub >= N)     sr = (sa < 0) ? -1 : 0;
        else if (sa >= 0) sr = sa / (1 << ub);
        else             sr = -((-sa + (1 << ub) - 1) / (1 << ub));
        r = (sr < 0) ? sr + M : sr;
      end
      default: e = 1'b1;
    endcase
    f = e ? 4'h0 : {c, v, (r >= H), (r == 0)};
    return {e, f & FMASK, N'(r)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL scoreboard: got result %h, required no result (queue empty)", {o_err, flags_obs, o_res});
        else if ({o_err, flags_obs, o_res} !== exp_q[0])
          $display("FAIL scoreboard: got %h required %h", {o_err, flags_obs, o_res}, exp_q[0]);
        else
          n_pass++;
        if (i_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(a, b, op));
        n_in++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] av, bv, input logic [5:0] opv);
    bit acc;
    acc = 1'b0;
    a = av; b = bv; op = opv; i_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: got o_ready=0 for 60 cycles, required acceptance");
    end
  endtask

  task automatic exec_one(input logic [N-1:0] av, bv, input logic [5:0] opv, output logic [W-1:0] obs);
    bit got;
    got = 1'b0;
    obs = 'x;
    send(av, bv, opv);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (o_valid) begin
        got = 1'b1;
        obs = {o_err, flags_obs, o_res};
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL result_timeout: got o_valid=0 for 20 cycles, required a result");
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a = 8'h5A; b = 8'h11; op = OP_ADD; i_valid = 1'b1;
    #3;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b required 0", o_valid); else n_pass++;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_o_ready: got %b required 1", o_ready); else n_pass++;
    n_checks++; if ({o_err, flags_obs, o_res} !== '0) $display("FAIL reset_outputs: got %h required 0", {o_err, flags_obs, o_res}); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_ignores_valid: got o_valid=%b required 0", o_valid); else n_pass++;
  endtask

  task automatic test_add_latency();
    logic [W-1:0] expv;
    expv = {1'b0, 4'b0110 & FMASK, 8'h80};
    a = 8'h7F; b = 8'h01; op = OP_ADD; i_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (o_ready !== 1'b1) $display("FAIL add_ready: got %b required 1", o_ready); else n_pass++;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL add_latency_edge1: got o_valid=%b required 0", o_valid); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b1) $display("FAIL add_latency_edge2: got o_valid=%b required 1", o_valid); else n_pass++;
    n_checks++; if ({o_err, flags_obs, o_res} !== expv) $display("FAIL add_7f_01: got %h required %h", {o_err, flags_obs, o_res}, expv); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    logic [N-1:0] ta [2];
    logic [N-1:0] tb [2];
    logic [W-1:0] te [2];
    logic [W-1:0] obs;
    ta[0] = 8'h00; tb[0] = 8'h01; te[0] = {1'b0, 4'b0010 & FMASK, 8'hFF};
    ta[1] = 8'h05; tb[1] = 8'h05; te[1] = {1'b0, 4'b1001 & FMASK, 8'h00};
    for (int i = 0; i < 2; i++) begin
      exec_one(ta[i], tb[i], OP_SUB, obs);
      n_checks++;
      if (obs !== te[i]) $display("FAIL sub_%0d: got %h required %h", i, obs, te[i]); else n_pass++;
    end
  endtask

  task automatic test_shift();
    logic [N-1:0] ta [3];
    logic [N-1:0] tb [3];
    logic [5:0]   to [3];
    logic [W-1:0] te [3];
    logic [W-1:0] obs;
    ta[0] = 8'h80; tb[0] = 8'd3; to[0] = OP_SRA; te[0] = {1'b0, 4'b0010 & FMASK, 8'hF0};
    ta[1] = 8'h80; tb[1] = 8'd9; to[1] = OP_SRA; te[1] = {1'b0, 4'b0010 & FMASK, 8'hFF};
    ta[2] = 8'h80; tb[2] = 8'd8; to[2] = OP_SRL; te[2] = {1'b0, 4'b0001 & FMASK, 8'h00};
    for (int i = 0; i < 3; i++) begin
      exec_one(ta[i], tb[i], to[i], obs);
      n_checks++;
      if (obs !== te[i]) $display("FAIL shift_%0d: got %h required %h", i, obs, te[i]); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] obs;
    exec_one(8'h12, 8'h34, 6'b111111, obs);
    n_checks++;
    if (obs !== {1'b1, 4'h0, 8'h00}) $display("FAIL illegal_op: got %h required %h", obs, {1'b1, 4'h0, 8'h00}); else n_pass++;
    exec_one(8'h01, 8'h02, OP_ADD, obs);
    n_checks++;
    if (obs !== {1'b0, 4'h0, 8'h03}) $display("FAIL after_illegal: got %h required %h", obs, {1'b0, 4'h0, 8'h03}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit saw_drop;
    int k;
    logic [W-1:0] expv;
    saw_drop = 1'b0;
    k = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(N'(i * 7), N'(i + 1), OP_ADD);
      end
      begin
        repeat (4) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!o_ready) saw_drop = 1'b1;
          @(posedge clk);
          #1;
        end
        i_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 80 && k < 10; t++) begin
          @(negedge clk);
          if (o_valid && i_ready) begin
            expv = model(N'(k * 7), N'(k + 1), OP_ADD);
            n_checks++;
            if ({o_err, flags_obs, o_res} !== expv)
              $display("FAIL b2b_result_%0d: got %h required %h", k, {o_err, flags_obs, o_res}, expv);
            else
              n_pass++;
            k++;
          end
        end
      end
    join
    n_checks++; if (saw_drop !== 1'b1) $display("FAIL b2b_ready_drop: got %b required 1", saw_drop); else n_pass++;
    n_checks++; if (k != 10) $display("FAIL b2b_count: got %0d required 10", k); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit done;
    int in0, out0, r;
    logic [5:0] legal [8];
    logic [5:0] opv;
    legal[0] = OP_ADD; legal[1] = OP_SUB; legal[2] = OP_AND; legal[3] = OP_OR;
    legal[4] = OP_XOR; legal[5] = OP_NOR; legal[6] = OP_SRL; legal[7] = OP_SRA;
    done = 1'b0;
    in0 = n_in;
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          r = $urandom_range(0, 9);
          opv = (r < 8) ? legal[r] : 6'($urandom);
          if ($urandom_range(0, 1) == 0) send(N'($urandom), N'($urandom_range(0, 11)), opv);
          else                           send(N'($urandom), N'($urandom), opv);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 i_ready = ($urandom_range(0, 2) != 0);
        end
        i_ready = 1'b1;
      end
    join
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    n_checks++;
    if ((n_in - in0) != 40) $display("FAIL random_accepted: got %0d required 40", n_in - in0); else n_pass++;
    n_checks++;
    if ((n_out - out0) != 40 || exp_q.size() != 0)
      $display("FAIL random_delivered: got %0d (pending %0d) required 40", n_out - out0, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_mid_reset();
    bit stale;
    logic [W-1:0] obs;
    i_ready = 1'b0;
    send(8'h11, 8'h22, OP_ADD);
    send(8'h33, 8'h44, OP_SUB);
    #2;
    n_checks++; if (o_valid !== 1'b1) $display("FAIL midrst_full_valid: got %b required 1", o_valid); else n_pass++;
    n_checks++; if (o_ready !== 1'b0) $display("FAIL midrst_full_ready: got %b required 0", o_ready); else n_pass++;
    rst_n = 1'b0;
    exp_q.delete();
    a = 8'h55; b = 8'h66; op = OP_XOR; i_valid = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL midrst_o_valid: got %b required 0", o_valid); else n_pass++;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL midrst_o_ready: got %b required 1", o_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    i_valid = 1'b0;
    i_ready = 1'b1;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_valid) stale = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++; if (stale !== 1'b0) $display("FAIL midrst_stale: got o_valid seen=%b required 0", stale); else n_pass++;
    exec_one(8'h10, 8'h20, OP_ADD, obs);
    n_checks++;
    if (obs !== {1'b0, 4'b0000, 8'h30}) $display("FAIL midrst_first_op: got %h required %h", obs, {1'b0, 4'b0000, 8'h30}); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_latency();
    test_sub();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_random();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
